imem_loader: RTL and testbench

- Writer side of the byte-addressed, little-endian instruction memory.
- Receives a framed program image over an 8-bit valid/ready byte stream and assembles each 4 bytes into a 32-bit instruction word.
- Issues one write per word to the memory write port at BASE_ADDR + 4*i.
- Holds the core in stall via busy while loading, and reports done or error.

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: writer side of the byte-addressed, little-endian instruction
// memory. Receives a framed program image over an 8-bit byte stream,
// assembles every 4 bytes into a 32-bit word and writes it to BASE_ADDR+4*i.
//
// Frame: N_lo, N_hi, 4*N payload bytes (byte 0 of each word first), CSUM,
// where CSUM is the XOR of all payload bytes.
//
// Handshake: a byte moves on a rising edge where rx_valid && rx_ready.
// rx_ready is a pure function of the state and never depends on rx_valid.
// A byte offered while rx_ready=0 is left in place for the producer.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          one-cycle pulse; honoured only in IDLE or ERR
//   rx_data        stream byte
//   rx_valid       rx_data is valid
//   rx_ready       loader can take a byte this cycle
//   mem_we         one-cycle write strobe per word
//   mem_addr       byte address of the word (held until the next write)
//   mem_wdata      word data, bits [8k+7:8k] belong to byte mem_addr+k
//   busy           load in progress, core stalled
//   done           one-cycle pulse on successful completion
//   error          sticky error flag, cleared by the next accepted start
//   words_loaded   words written in the current load
//   fsm_state      current FSM state, for debug and checkers
module imem_loader #(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter logic [63:0] MEM_BYTES = 64'd121
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded,
  output logic [2:0]  fsm_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_LO = 3'd1;
  localparam logic [2:0] S_HDR_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  logic [2:0]  state;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] asm_lo;     // lanes 0..2; lane 3 is taken straight from rx_data
  logic [7:0]  csum;
  logic        accept;
  logic [63:0] image_end;

  assign accept = rx_valid && rx_ready;

  // End address of the image, evaluated while the N_hi byte is on the bus.
  // 64-bit arithmetic, so 4*N never overflows.
  assign image_end = BASE_ADDR + {46'd0, rx_data, n_words[7:0], 2'b00};

  assign fsm_state = state;
  assign rx_ready  = (state == S_HDR_LO) || (state == S_HDR_HI) ||
                     (state == S_DATA)   || (state == S_CSUM);
  assign busy      = rx_ready || (state == S_WRITE);
  assign mem_we    = (state == S_WRITE);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      n_words      <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      asm_lo       <= '0;
      csum         <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            state        <= S_HDR_LO;
            words_loaded <= '0;
            csum         <= '0;
            byte_idx     <= '0;
            word_idx     <= '0;
          end
        end
        S_HDR_LO: begin
          if (accept) begin
            n_words[7:0] <= rx_data;
            state        <= S_HDR_HI;
          end
        end
        S_HDR_HI: begin
          if (accept) begin
            n_words[15:8] <= rx_data;
            if (image_end > MEM_BYTES)
              state <= S_ERR;
            else if ({rx_data, n_words[7:0]} == 16'd0)
              state <= S_CSUM;
            else
              state <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    asm_lo[7:0]   <= rx_data;
              2'd1:    asm_lo[15:8]  <= rx_data;
              2'd2:    asm_lo[23:16] <= rx_data;
              default: begin
                // Last lane: load the write registers now so the strobe
                // follows one cycle after this accept edge.
                mem_wdata <= {rx_data, asm_lo};
                mem_addr  <= BASE_ADDR + {46'd0, word_idx, 2'b00};
                state     <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          word_idx     <= word_idx + 16'd1;
          words_loaded <= words_loaded + 16'd1;
          state        <= (word_idx + 16'd1 == n_words) ? S_CSUM : S_DATA;
        end
        S_CSUM: begin
          // Words already written stay written on a mismatch.
          if (accept)
            state <= (rx_data == csum) ? S_DONE : S_ERR;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. A frame-level model computes the
// expected writes and outcome of each image; one compare process checks
// the outputs every cycle against that model.
module tb_imem_loader;

  localparam logic [63:0] BASE = 64'd0;
  localparam logic [63:0] MEMB = 64'd121;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  logic [2:0]  fsm_state;

  imem_loader #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [63:0] exp_addr_q[$];
  logic [31:0] frame_words[$];
  int          done_cnt  = 0;
  int          write_cnt = 0;
  logic        prev_done = 1'b0;
  logic        seen_write = 1'b0;
  logic [63:0] last_addr = '0;
  logic [31:0] last_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    $display("FAIL %s: event not expected / did not occur", name);
  endtask

  function automatic logic [7:0] model_csum(input logic [31:0] w[$]);
    logic [7:0] x = 8'h00;
    foreach (w[j])
      for (int k = 0; k < 4; k++) x = x ^ w[j][8*k +: 8];
    return x;
  endfunction

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    if (reset) begin
      check("reset_ctrl", {43'd0, mem_we, busy, done, error, rx_ready, words_loaded}, 64'd0);
      check("reset_addr", mem_addr, 64'd0);
      check("reset_wdata", {32'd0, mem_wdata}, 64'd0);
      seen_write = 1'b0;
      last_addr  = '0;
      last_data  = '0;
      prev_done  = 1'b0;
    end else begin
      if (mem_we) begin
        write_cnt++;
        if (exp_q.size() == 0) fail_event("unexpected_write");
        else begin
          check("write_addr", mem_addr, exp_addr_q.pop_front());
          check("write_data", {32'd0, mem_wdata}, {32'd0, exp_q.pop_front()});
        end
        check("ready_in_write", {63'd0, rx_ready}, 64'd0);
        check("busy_in_write", {63'd0, busy}, 64'd1);
        seen_write = 1'b1;
        last_addr  = mem_addr;
        last_data  = mem_wdata;
      end else if (seen_write) begin
        check("addr_stable", mem_addr, last_addr);
        check("wdata_stable", {32'd0, mem_wdata}, {32'd0, last_data});
      end
      if (done) begin
        done_cnt++;
        check("done_busy_low", {63'd0, busy}, 64'd0);
        check("done_one_cycle", {63'd0, prev_done}, 64'd0);
      end
      if (error)
        check("error_quiet", {61'd0, busy, rx_ready, mem_we}, 64'd0);
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called and returns at a negedge. Holds the byte until it is taken.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int   gap;
    logic accepted;
    gap      = $urandom_range(0, max_gap);
    accepted = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 200; t++) begin
      if (rx_ready) begin
        @(posedge clk);
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) fail_event("accept_timeout");
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Load frame_words as an image of n words (n may disagree with the word
  // list only for oversize images, where no payload is sent).
  task automatic run_frame(input int n, input bit bad_csum, input int max_gap, input bit poke_start);
    bit         oversize;
    bit         ok;
    int         n_wr;
    int         d0;
    int         w0;
    logic [7:0] cs;
    oversize = (longint'(BASE) + 4 * longint'(n)) > longint'(MEMB);
    ok       = !oversize && !bad_csum;
    n_wr     = oversize ? 0 : n;
    for (int j = 0; j < n_wr; j++) begin
      exp_q.push_back(frame_words[j]);
      exp_addr_q.push_back(BASE + 64'(4 * j));
    end
    d0 = done_cnt;
    w0 = write_cnt;
    pulse_start();
    check("start_busy", {63'd0, busy}, 64'd1);
    check("start_clears_error", {63'd0, error}, 64'd0);
    check("start_clears_count", {48'd0, words_loaded}, 64'd0);
    send_byte(8'(n), max_gap);
    send_byte(8'(n >> 8), max_gap);
    if (!oversize) begin
      if (poke_start) pulse_start();   // must be ignored while busy
      for (int j = 0; j < n; j++)
        for (int k = 0; k < 4; k++) send_byte(frame_words[j][8*k +: 8], max_gap);
      cs = model_csum(frame_words);
      if (bad_csum) cs = cs ^ 8'($urandom_range(1, 255));
      send_byte(cs, max_gap);
    end
    for (int t = 0; t < 50 && busy; t++) @(negedge clk);
    check("frame_ends", {63'd0, busy}, 64'd0);
    check("done_count", 64'(done_cnt - d0), ok ? 64'd1 : 64'd0);
    check("error_flag", {63'd0, error}, ok ? 64'd0 : 64'd1);
    check("write_count", 64'(write_cnt - w0), 64'(n_wr));
    check("words_loaded", {48'd0, words_loaded}, 64'(n_wr));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    if (!ok) check("err_ready_low", {63'd0, rx_ready}, 64'd0);
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Pin the model against hand-computed checksums.
    frame_words = '{32'h10000993};
    check("model_csum_1w", {56'd0, model_csum(frame_words)}, 64'h8A);
    frame_words = '{32'h10000913, 32'h00700993};
    check("model_csum_2w", {56'd0, model_csum(frame_words)}, 64'hE0);

    // One-word load.
    frame_words = '{32'h10000993};
    run_frame(1, 1'b0, 0, 1'b0);
    check("one_word_data", {32'd0, mem_wdata}, 64'h10000993);
    check("one_word_addr", mem_addr, 64'd0);

    // Two words with random gaps and a start pulse during the load.
    frame_words = '{32'h10000913, 32'h00700993};
    run_frame(2, 1'b0, 4, 1'b1);
    check("two_word_addr", mem_addr, 64'd4);

    // Bounds: one word too many, then the largest image.
    frame_words = {};
    run_frame(31, 1'b0, 2, 1'b0);
    frame_words = {};
    for (int j = 0; j < 30; j++) frame_words.push_back($urandom);
    run_frame(30, 1'b0, 1, 1'b0);
    check("max_last_addr", mem_addr, 64'd116);
    check("max_words", {48'd0, words_loaded}, 64'd30);

    // Bad checksum, then an empty image (its start clears the error).
    frame_words = '{32'h10000993};
    run_frame(1, 1'b1, 1, 1'b0);
    frame_words = {};
    run_frame(0, 1'b0, 2, 1'b0);

    // Reset in the middle of word 0.
    pulse_start();
    send_byte(8'h01, 1);
    send_byte(8'h00, 1);
    send_byte(8'h93, 1);
    send_byte(8'h09, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("post_reset_count", {48'd0, words_loaded}, 64'd0);
    frame_words = '{32'h10000993};
    run_frame(1, 1'b0, 2, 1'b0);
    check("after_reset_data", {32'd0, mem_wdata}, 64'h10000993);

    // Random images.
    for (int f = 0; f < 10; f++) begin
      int n;
      n = (f % 5 == 4) ? int'($urandom_range(31, 65535)) : int'($urandom_range(0, 12));
      frame_words = {};
      if (n <= 30)
        for (int j = 0; j < n; j++) frame_words.push_back($urandom);
      run_frame(n, ($urandom_range(0, 3) == 0), 3, ($urandom_range(0, 1) == 1));
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
